// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Buffered 8N1 UART transmitter. CPU byte writes are queued in a
//            DEPTH-entry FIFO and serialised LSB-first onto uartTxPin, with
//            queued bytes sent back-to-back (no idle gap between frames).
// Ports    : CLK        system clock, rising edge
//            RST        asynchronous active-low reset
//            WDATA[7:0] byte to enqueue
//            WE         enqueue strobe, one byte per cycle while high
//            CLR_OVF    clears the sticky OVERFLOW flag
//            FULL       FIFO holds DEPTH entries
//            EMPTY      FIFO holds 0 entries
//            COUNT      FIFO occupancy, $clog2(DEPTH)+1 bits
//            BUSY       serialiser is framing a byte (not IDLE)
//            OVERFLOW   sticky: a write was dropped because the FIFO was full
//            uartTxPin  serial line, idle high
// Params   : CLKS_PER_BIT (>= 2) clock cycles per serial bit
//            DEPTH (power of two, >= 2) FIFO entries
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH        = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [7:0]               WDATA,
    input  logic                     WE,
    input  logic                     CLR_OVF,
    output logic                     FULL,
    output logic                     EMPTY,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     BUSY,
    output logic                     OVERFLOW,
    output logic                     uartTxPin
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_BW = $clog2(CLKS_PER_BIT);

    localparam logic [c_BW-1:0] c_BAUD_LAST  = c_BW'(CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0] c_COUNT_FULL = c_CW'(DEPTH);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    // FIFO state
    logic [7:0]      mem_q [DEPTH];
    logic [c_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_CW-1:0] count_q,  count_d;
    logic            ovf_q,    ovf_d;

    // Serialiser state
    logic [1:0]      state_q,   state_d;
    logic [c_BW-1:0] baud_q,    baud_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q,   shift_d;
    logic            tx_q,      tx_d;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_baud_wrap;

    assign w_full      = (count_q == c_COUNT_FULL);
    assign w_empty     = (count_q == '0);
    // FULL is the only gate on writes: a pop in the same cycle does not
    // make room for the incoming byte.
    assign w_push      = WE && !w_full;
    assign w_baud_wrap = (baud_q == c_BAUD_LAST);

    // ------------------------------------------------------------------
    // Serialiser next-state. tx_d is the level the line will carry during
    // the next cycle, so every transition pre-loads the level of the bit
    // that is about to start.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        w_pop     = 1'b0;

        case (state_q)
            c_IDLE: begin
                tx_d = 1'b1;
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = '0;
                    state_d = c_START;
                    tx_d    = 1'b0;
                end
            end
            c_START: begin
                if (w_baud_wrap) begin
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    state_d   = c_DATA;
                    tx_d      = shift_q[0];
                end else begin
                    baud_d = baud_q + c_BW'(1);
                end
            end
            c_DATA: begin
                if (w_baud_wrap) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = c_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + c_BW'(1);
                end
            end
            c_STOP: begin
                if (w_baud_wrap) begin
                    baud_d = '0;
                    if (!w_empty) begin
                        // Chain straight into the next frame's start bit.
                        w_pop   = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = c_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = c_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + c_BW'(1);
                end
            end
            default: begin
                state_d = c_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO pointers, occupancy and sticky overflow
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = w_push ? wr_ptr_q + c_AW'(1) : wr_ptr_q;
        rd_ptr_d = w_pop  ? rd_ptr_q + c_AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CW'(1);
            2'b01:   count_d = count_q - c_CW'(1);
            default: count_d = count_q;
        endcase
        // A new drop takes priority over a clear in the same cycle.
        if (WE && w_full) begin
            ovf_d = 1'b1;
        end else if (CLR_OVF) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            state_q   <= c_IDLE;
            baud_q    <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= WDATA;
        end
    end

    assign FULL      = w_full;
    assign EMPTY     = w_empty;
    assign COUNT     = count_q;
    assign BUSY      = (state_q != c_IDLE);
    assign OVERFLOW  = ovf_q;
    assign uartTxPin = tx_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Self-checking bench for uart_tx_fifo (CLKS_PER_BIT=4, DEPTH=4).
//            A cycle-vector table checks flags and latency, a frame table
//            holds hand-computed line patterns, and a line receiver decodes
//            every frame into a queue for order/content checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int CPB = 4;
    localparam int DEP = 4;

    logic       CLK;
    logic       RST;
    logic [7:0] WDATA;
    logic       WE;
    logic       CLR_OVF;
    logic       FULL;
    logic       EMPTY;
    logic [2:0] COUNT;
    logic       BUSY;
    logic       OVERFLOW;
    logic       uartTxPin;

    int checks = 0;
    int errors = 0;

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB),
        .DEPTH       (DEP)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .WDATA    (WDATA),
        .WE       (WE),
        .CLR_OVF  (CLR_OVF),
        .FULL     (FULL),
        .EMPTY    (EMPTY),
        .COUNT    (COUNT),
        .BUSY     (BUSY),
        .OVERFLOW (OVERFLOW),
        .uartTxPin(uartTxPin)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish required finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Line receiver: samples on the falling clock edge, bit j is taken
    // 4*j+2 cycles after the first low sample (mid-bit).
    // ------------------------------------------------------------------
    int         cyc        = 0;
    int         busy_total = 0;
    int         busy_rises = 0;
    int         empty_viol = 0;
    logic       prev_busy  = 1'b0;
    logic       rx_active  = 1'b0;
    int         rx_phase   = 0;
    int         rx_start   = 0;
    logic [9:0] rx_line    = '0;
    logic [9:0] rx_q[$];
    int         rx_start_q[$];

    always @(negedge CLK) begin
        cyc       <= cyc + 1;
        prev_busy <= BUSY;
        if (BUSY) busy_total <= busy_total + 1;
        if (BUSY && !prev_busy) busy_rises <= busy_rises + 1;
        if (BUSY && !EMPTY) empty_viol <= empty_viol + 1;
        if (!RST) begin
            rx_active <= 1'b0;
        end else if (!rx_active) begin
            if (uartTxPin == 1'b0) begin
                rx_active <= 1'b1;
                rx_phase  <= 1;
                rx_start  <= cyc;
            end
        end else begin
            if (rx_phase % 4 == 2) rx_line[rx_phase / 4] <= uartTxPin;
            if (rx_phase == 38) begin
                rx_q.push_back({uartTxPin, rx_line[8:0]});
                rx_start_q.push_back(rx_start);
                rx_active <= 1'b0;
            end
            rx_phase <= rx_phase + 1;
        end
    end

    // ------------------------------------------------------------------
    // Tables
    // ------------------------------------------------------------------
    typedef struct packed {
        logic       we;
        logic [7:0] wdata;
        logic       clr;
        logic       exp_tx;
        logic       exp_busy;
        logic       exp_empty;
        logic       exp_full;
        logic       exp_ovf;
        logic [2:0] exp_cnt;
    } vec_t;

    typedef struct packed {
        logic [7:0] data;
        logic [9:0] line;   // bit 0 = start bit, bit 9 = stop bit
    } frame_t;

    vec_t   tbl[7];
    frame_t ftbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_rows(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            WE      = tbl[i].we;
            WDATA   = tbl[i].wdata;
            CLR_OVF = tbl[i].clr;
            tick();
            check($sformatf("row%0d tx", i),    uartTxPin, tbl[i].exp_tx);
            check($sformatf("row%0d busy", i),  BUSY,      tbl[i].exp_busy);
            check($sformatf("row%0d empty", i), EMPTY,     tbl[i].exp_empty);
            check($sformatf("row%0d full", i),  FULL,      tbl[i].exp_full);
            check($sformatf("row%0d ovf", i),   OVERFLOW,  tbl[i].exp_ovf);
            check($sformatf("row%0d count", i), COUNT,     tbl[i].exp_cnt);
        end
        WE      = 1'b0;
        CLR_OVF = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        while ((BUSY || !EMPTY) && n < limit) begin
            tick();
            n++;
        end
        check({name, " idle timeout"}, (BUSY || !EMPTY), 1'b0);
    endtask

    task automatic wait_frames(input string name, input int n, input int limit);
        int k = 0;
        while (rx_q.size() < n && k < limit) begin
            tick();
            k++;
        end
        check({name, " frames received"}, (rx_q.size() >= n), 1'b1);
    endtask

    task automatic check_line(input string name, input int idx, input logic [9:0] exp);
        logic [9:0] got;
        got = (idx < rx_q.size()) ? rx_q[idx] : 10'h000;
        check(name, got, exp);
    endtask

    int         base;
    int         b_busy;
    int         b_rise;
    int         b_ev;
    int         sent;
    int         n;
    logic [7:0] ovf_bytes[5];

    initial begin
        //              we  wdata  clr tx busy empty full ovf cnt
        tbl[0] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
        tbl[1] = '{1'b1, 8'h41, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
        tbl[3] = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1};
        tbl[4] = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1};
        tbl[5] = '{1'b1, 8'h0F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2};

        ftbl[0] = '{8'h41, 10'b1010000010};
        ftbl[1] = '{8'h55, 10'b1010101010};
        ftbl[2] = '{8'hAA, 10'b1101010100};
        ftbl[3] = '{8'h0F, 10'b1000011110};
        ftbl[4] = '{8'h7E, 10'b1011111100};

        ovf_bytes = '{8'h11, 8'hA1, 8'hA2, 8'hA3, 8'hA4};

        RST = 1'b0; WE = 1'b0; CLR_OVF = 1'b0; WDATA = 8'h00;
        repeat (3) tick();
        check("reset tx",    uartTxPin, 1'b1);
        check("reset busy",  BUSY,      1'b0);
        check("reset empty", EMPTY,     1'b1);
        check("reset full",  FULL,      1'b0);
        check("reset count", COUNT,     3'd0);
        check("reset ovf",   OVERFLOW,  1'b0);
        RST = 1'b1;

        // ---------------- single byte 0x41 ----------------
        base   = rx_q.size();
        b_busy = busy_total;
        b_ev   = empty_viol;
        run_rows(0, 2);
        wait_idle("single", 100);
        wait_frames("single", base + 1, 20);
        check_line("single line 0x41", base, ftbl[0].line);
        check("single busy cycles", busy_total - b_busy, 40);
        check("single empty during frame", empty_viol - b_ev, 0);

        // ---------------- burst 0x55 0xAA 0x0F ----------------
        base   = rx_q.size();
        b_busy = busy_total;
        b_rise = busy_rises;
        run_rows(3, 6);
        wait_frames("burst", base + 3, 200);
        wait_idle("burst", 100);
        for (int i = 0; i < 3; i++)
            check_line($sformatf("burst line %0d", i), base + i, ftbl[1 + i].line);
        check("burst busy cycles", busy_total - b_busy, 120);
        check("burst busy rises", busy_rises - b_rise, 1);
        if (rx_start_q.size() >= base + 3) begin
            check("burst gap 1->2", rx_start_q[base + 1] - rx_start_q[base], 40);
            check("burst gap 2->3", rx_start_q[base + 2] - rx_start_q[base + 1], 40);
        end

        // ---------------- overflow ----------------
        base = rx_q.size();
        WE = 1'b1; WDATA = 8'h11; tick();
        WE = 1'b0; tick();
        check("ovf setup busy",  BUSY,  1'b1);
        check("ovf setup count", COUNT, 3'd0);
        for (int i = 0; i < 5; i++) begin
            WE = 1'b1; WDATA = 8'hA1 + 8'(i);
            tick();
            if (i == 3) begin
                check("ovf full after 4th",  FULL,     1'b1);
                check("ovf count after 4th", COUNT,    3'd4);
                check("ovf flag after 4th",  OVERFLOW, 1'b0);
            end
        end
        WE = 1'b0;
        check("ovf flag after 5th",  OVERFLOW, 1'b1);
        check("ovf count after 5th", COUNT,    3'd4);
        WE = 1'b1; WDATA = 8'hEE; CLR_OVF = 1'b1; tick();
        check("ovf clr with drop", OVERFLOW, 1'b1);
        WE = 1'b0; tick();
        check("ovf cleared", OVERFLOW, 1'b0);
        CLR_OVF = 1'b0;
        wait_frames("ovf", base + 5, 400);
        wait_idle("ovf", 100);
        for (int i = 0; i < 5; i++)
            check_line($sformatf("ovf byte %0d", i), base + i, {1'b1, ovf_bytes[i], 1'b0});
        check("ovf frame count", rx_q.size() - base, 5);

        // ---------------- wrap-around stream ----------------
        base = rx_q.size();
        sent = 0;
        n    = 0;
        while (sent < 10 && n < 2000) begin
            if (!FULL) begin
                WE = 1'b1; WDATA = 8'(sent);
            end else begin
                WE = 1'b0;
            end
            tick();
            if (WE) sent++;
            n++;
        end
        WE = 1'b0;
        check("wrap bytes written", sent, 10);
        wait_frames("wrap", base + 10, 800);
        wait_idle("wrap", 100);
        for (int i = 0; i < 10; i++)
            check_line($sformatf("wrap byte %0d", i), base + i, {1'b1, 8'(i), 1'b0});
        check("wrap ovf", OVERFLOW, 1'b0);

        // ---------------- reset mid-frame ----------------
        WE = 1'b1; WDATA = 8'h34; tick();
        WDATA = 8'hC3; tick();
        WDATA = 8'h99; tick();
        WE = 1'b0;
        check("rst setup count", COUNT, 3'd2);
        repeat (16) tick();
        // 17 cycles after the start bit began: middle of data bit 3 (0)
        check("rst pre tx bit3", uartTxPin, 1'b0);
        RST = 1'b0;
        #2;
        check("rst async tx",    uartTxPin, 1'b1);
        check("rst async busy",  BUSY,      1'b0);
        check("rst async empty", EMPTY,     1'b1);
        check("rst async count", COUNT,     3'd0);
        repeat (3) tick();
        RST = 1'b1;
        base = rx_q.size();
        WE = 1'b1; WDATA = ftbl[4].data; tick();
        WE = 1'b0;
        wait_frames("rst", base + 1, 100);
        wait_idle("rst", 100);
        repeat (50) tick();
        check_line("rst line 0x7E", base, ftbl[4].line);
        check("rst frame count", rx_q.size() - base, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
